// File: rtl/sisc_pkg.sv
// sisc_pkg: shared definitions for the SISC core front end.
// Holds datapath widths, the opcode map, the fetch-state encoding and the
// instruction-register field positions. Field extraction helpers keep IR
// slicing in one place so decoders never hard-code bit numbers.
package sisc_pkg;

    // Datapath widths
    localparam int unsigned PC_W   = 16;
    localparam int unsigned IR_W   = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned MM_W   = 4;
    localparam int unsigned STAT_W = 4;
    localparam int unsigned IMM_W  = 16;

    // IR field positions (least-significant bit of each field)
    localparam int unsigned IR_OP_LSB  = 28;
    localparam int unsigned IR_MM_LSB  = 24;
    localparam int unsigned IR_IMM_LSB = 0;

    // Opcode map
    localparam logic [OP_W-1:0] OP_NOOP = 4'd0;
    localparam logic [OP_W-1:0] OP_LOD  = 4'd1;
    localparam logic [OP_W-1:0] OP_STR  = 4'd2;
    localparam logic [OP_W-1:0] OP_SWP  = 4'd3;
    localparam logic [OP_W-1:0] OP_BRA  = 4'd4;
    localparam logic [OP_W-1:0] OP_BRR  = 4'd5;
    localparam logic [OP_W-1:0] OP_BNE  = 4'd6;
    localparam logic [OP_W-1:0] OP_BNR  = 4'd7;
    localparam logic [OP_W-1:0] OP_ALU  = 4'd8;
    localparam logic [OP_W-1:0] OP_HLT  = 4'd15;

    // Instruction-fetch state encoding
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DONE = 2'd2
    } fetch_state_e;

    // IR field extraction helpers
    function automatic logic [OP_W-1:0] ir_opcode(input logic [IR_W-1:0] ir);
        return ir[IR_OP_LSB +: OP_W];
    endfunction

    function automatic logic [MM_W-1:0] ir_mm(input logic [IR_W-1:0] ir);
        return ir[IR_MM_LSB +: MM_W];
    endfunction

    function automatic logic [IMM_W-1:0] ir_imm(input logic [IR_W-1:0] ir);
        return ir[IR_IMM_LSB +: IMM_W];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read bus.
//   imem_req  : read request, held until acknowledged
//   imem_addr : word address, stable while imem_req is high
//   imem_ack  : memory returns valid data this cycle
//   imem_data : instruction word
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if;
    import sisc_pkg::*;

    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [IR_W-1:0]   imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/br_cond.sv
// br_cond: branch condition evaluation for the instruction in IR.
//   opcode   in  4 : IR opcode field
//   mm       in  4 : IR condition mask
//   stat     in  4 : status register {C,N,O,Z}
//   br_taken out 1 : branch taken (combinational)
// BRA/BRR branch when any masked status bit is set, BNE/BNR when none is.
module br_cond
    import sisc_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [MM_W-1:0]   mm,
    input  logic [STAT_W-1:0] stat,
    output logic              br_taken
);

    logic w_hit;

    assign w_hit = |(stat & mm);

    // Condition select by opcode
    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            OP_BRA, OP_BRR: br_taken = w_hit;
            OP_BNE, OP_BNR: br_taken = ~w_hit;
            default:        br_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register, status register and
// instruction fetch sequencer of the SISC core.
//   clk, rst      : clock, synchronous active-high reset
//   pc_rst        : force PC to 0 (wins over pc_write)
//   pc_write      : update PC this cycle
//   pc_sel        : 0 = PC+1, 1 = branch target
//   br_sel        : 0 = PC+1+imm, 1 = imm
//   ir_load       : start a fetch at the current PC (ignored while busy)
//   stat_we       : load stat_in into the status register
//   stat_in       : ALU status {C,N,O,Z}
//   imem          : instruction-memory bus (master side)
//   opcode/mm/imm : IR field decodes
//   stat          : status register
//   pc_out        : current PC
//   br_taken      : branch condition for the current IR
//   fetch_busy    : fetch outstanding
// All outputs are decodes of PC, IR, stat and the fetch state register.
module fetch_unit
    import sisc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    input  logic               stat_we,
    input  logic [STAT_W-1:0]  stat_in,
    fetch_unit_if.master       imem,
    output logic [OP_W-1:0]    opcode,
    output logic [MM_W-1:0]    mm,
    output logic [STAT_W-1:0]  stat,
    output logic [IMM_W-1:0]   imm,
    output logic [PC_W-1:0]    pc_out,
    output logic               br_taken,
    output logic               fetch_busy
);

    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_addr;
    logic [IR_W-1:0]   r_ir;
    logic [STAT_W-1:0] r_stat;
    fetch_state_e      r_state;

    logic [OP_W-1:0]   w_opcode;
    logic [MM_W-1:0]   w_mm;
    logic [IMM_W-1:0]  w_imm;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_next;
    logic              w_in_req;
    logic              w_unused_ir;

    // IR field decode
    assign w_opcode = ir_opcode(r_ir);
    assign w_mm     = ir_mm(r_ir);
    assign w_imm    = ir_imm(r_ir);

    // IR[23:16] carries no meaning for the fetch unit
    assign w_unused_ir = ^r_ir[23:16];

    // Next PC: modulo-2^16 arithmetic, imm treated as two's complement
    assign w_pc_inc = r_pc + PC_W'(1);

    always_comb begin
        w_pc_next = w_pc_inc;
        if (pc_sel) begin
            if (br_sel) begin
                w_pc_next = PC_W'(w_imm);
            end else begin
                w_pc_next = w_pc_inc + PC_W'(w_imm);
            end
        end
    end

    // PC, status, IR and fetch sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_addr  <= '0;
            r_ir    <= '0;
            r_stat  <= '0;
            r_state <= FS_IDLE;
        end else begin
            if (pc_rst) begin
                r_pc <= '0;
            end else if (pc_write) begin
                r_pc <= w_pc_next;
            end

            if (stat_we) begin
                r_stat <= stat_in;
            end

            case (r_state)
                FS_IDLE: begin
                    // Captures the PC before any same-cycle pc_write lands
                    if (ir_load) begin
                        r_addr  <= r_pc;
                        r_state <= FS_REQ;
                    end
                end
                FS_REQ: begin
                    // Waits indefinitely; memory latency is unbounded
                    if (imem.imem_ack) begin
                        r_ir    <= imem.imem_data;
                        r_state <= FS_DONE;
                    end
                end
                FS_DONE: begin
                    r_state <= FS_IDLE;
                end
                default: begin
                    r_state <= FS_IDLE;
                end
            endcase
        end
    end

    // Output decodes
    assign w_in_req       = (r_state == FS_REQ);
    assign imem.imem_req  = w_in_req;
    assign imem.imem_addr = w_in_req ? r_addr : r_pc;
    assign fetch_busy     = w_in_req;
    assign opcode         = w_opcode;
    assign mm             = w_mm;
    assign imm            = w_imm;
    assign stat           = r_stat;
    assign pc_out         = r_pc;

    br_cond u_br_cond (
        .opcode   (w_opcode),
        .mm       (w_mm),
        .stat     (r_stat),
        .br_taken (br_taken)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset; one clock; sampled on rising clk edge only.
REQ-003 pc_rst  in  1  from control FSM: force PC to 0.
REQ-004 pc_write  in  1  from control FSM: update PC this cycle.
REQ-005 pc_sel  in  1  0 = sequential (PC+1), 1 = branch target.
REQ-006 br_sel  in  1  0 = relative target (PC+1+imm), 1 = absolute target (imm).
REQ-007 ir_load  in  1  from control FSM: start instruction fetch at current PC.
REQ-008 stat_we  in  1  ALU status write enable.
REQ-009 stat_in  in  4  ALU status code {C,N,O,Z}.
REQ-010 imem_ack  in  1  instruction memory: data valid this cycle.
REQ-011 imem_data  in  32  instruction memory read data.
REQ-012 imem_req  out  1  instruction memory read request.
REQ-013 imem_addr  out  16  instruction memory word address.
REQ-014 opcode  out  4  IR[31:28], to control FSM.
REQ-015 mm  out  4  IR[27:24], to control FSM.
REQ-016 stat  out  4  status register, to control FSM.
REQ-017 imm  out  16  IR[15:0].
REQ-018 pc_out  out  16  current PC.
REQ-019 br_taken  out  1  branch condition result for current IR.
REQ-020 fetch_busy  out  1  high while a fetch is outstanding.

Function
REQ-021 PC, IR, stat, fetch state SHALL be registers; all other outputs SHALL be combinational decodes of them.
REQ-022 PC update priority: pc_rst (PC=0) > pc_write; pc_write with pc_sel=0 gives PC+1, pc_sel=1 and br_sel=0 gives PC+1+imm, pc_sel=1 and br_sel=1 gives imm.
REQ-023 PC arithmetic SHALL be 16-bit modulo; 16'hFFFF+1 wraps to 0; imm added as two's-complement, no overflow flag.
REQ-024 stat SHALL load stat_in on the cycle stat_we is high; else hold.
REQ-025 br_taken: opcode BRA(4)/BRR(5) -> 1 iff (stat & mm) != 0; BNE(6)/BNR(7) -> 1 iff (stat & mm) == 0; all other opcodes -> 0.
REQ-026 Fetch FSM states: IDLE, REQ, DONE.
REQ-027 IDLE: ir_load high -> capture PC into address register, go REQ next cycle; else stay.
REQ-028 REQ: imem_req=1, imem_addr=captured address (stable until ack); imem_ack high -> IR loads imem_data, go DONE; else stay REQ with no timeout.
REQ-029 DONE: one cycle, imem_req=0, then IDLE; new IR visible on opcode/mm/imm from the first cycle of DONE.
REQ-030 fetch_busy SHALL be high in REQ, low in IDLE and DONE.
REQ-031 ir_load while in REQ or DONE SHALL be ignored (no queuing).
REQ-032 imem_ack in IDLE or DONE SHALL be ignored; IR unchanged.
REQ-033 ir_load and pc_write in the same cycle: fetch SHALL use PC before the update; PC updates normally.
REQ-034 imem_addr SHALL equal pc_out when not in REQ.

Reset
REQ-035 rst high at rising edge: PC=0, IR=32'h0 (NOOP), stat=0, fetch state IDLE, imem_req=0, fetch_busy=0, br_taken=0.
REQ-036 rst mid-fetch SHALL abort: imem_req drops the next cycle, a coincident imem_ack is discarded.
REQ-037 rst SHALL override pc_rst, pc_write, stat_we, ir_load in the same cycle.

Structure
REQ-038 Opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15), fetch-state encoding and IR field positions SHALL live in shared package sisc_pkg.
REQ-039 Branch condition logic SHALL be a sub-module br_cond (inputs opcode, mm, stat; output br_taken); all else in fetch_unit.

Verification
REQ-040 Reset then ir_load, memory acks after 3 cycles with 32'h1800_0005 -> imem_addr=0 held 3 cycles, opcode=1, mm=8, imm=5 in DONE, fetch_busy high exactly 3 cycles.
REQ-041 PC=16'h0010, imm=16'hFFFE, pc_write, pc_sel=1, br_sel=0 -> PC=16'h000F; repeat with br_sel=1 -> PC=16'hFFFE; then pc_write, pc_sel=0 -> PC=16'hFFFF, again -> 16'h0000.
REQ-042 stat_we with stat_in=4'b0001, IR opcode=4, mm=4'b0001 -> br_taken=1; opcode=6 same mm -> br_taken=0; opcode=8 -> br_taken=0.
REQ-043 ir_load and pc_write (pc_sel=0) together at PC=7 -> imem_addr=7, PC=8 next cycle; second ir_load during REQ produces no extra request.
REQ-044 rst asserted while in REQ, imem_ack same cycle -> IR=0, state IDLE, imem_req=0 next cycle.
REQ-045 pc_rst and pc_write together at PC=9 -> PC=0.
